// File: rtl/netlist_cone_pipe.sv
// Two-stage bitwise cone pipeline: S1 registers the majority cone per beat,
// S2 holds either a pass result or an accumulated frame result.
module netlist_cone_pipe #(
  parameter int W     = 4,
  parameter int LANES = 2,
  parameter int CW    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*W-1:0]   in_a,
  input  logic [LANES*W-1:0]   in_b,
  input  logic [LANES*W-1:0]   in_c,
  input  logic                 in_mode,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   out_y,
  output logic [CW-1:0]        out_cnt
);

  localparam int N = LANES * W;

  logic [N-1:0]  cone_x;
  logic [N-1:0]  cone_z;
  logic [N-1:0]  cone_f;

  logic          s1_valid;
  logic [N-1:0]  s1_f;
  logic          s1_mode;
  logic          s1_last;

  logic [N-1:0]  acc;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  logic          s1_emit;
  logic          s1_adv;
  logic          accept;

  // Purely bitwise: every bit position is its own cone, so lanes cannot interact.
  always_comb begin
    cone_x = ~(in_a & in_b);
    cone_z = in_a ^ in_b;
    cone_f = (cone_x & in_c) | (cone_x & cone_z) | (in_c & cone_z);
  end

  always_comb begin
    s1_emit  = ~s1_mode | s1_last;
    // A non-emitting accumulate beat never needs S2, so it drains even under backpressure.
    s1_adv   = s1_valid & (~out_valid | out_ready | ~s1_emit);
    in_ready = rst_n & (~s1_valid | s1_adv);
    accept   = in_valid & in_ready;
    cnt_inc  = (cnt == '1) ? cnt : cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_f      <= '0;
      s1_mode   <= 1'b0;
      s1_last   <= 1'b0;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_cnt   <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_f     <= cone_f;
        s1_mode  <= in_mode;
        s1_last  <= in_last;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (s1_adv && !s1_mode) begin
        out_valid <= 1'b1;
        out_y     <= s1_f;
        out_cnt   <= CW'(1);
      end else if (s1_adv && s1_last) begin
        out_valid <= 1'b1;
        out_y     <= acc ^ s1_f;
        out_cnt   <= cnt_inc;
        acc       <= '0;
        cnt       <= '0;
      end else begin
        if (s1_adv) begin
          acc <= acc ^ s1_f;
          cnt <= cnt_inc;
        end
        if (out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/netlist_cone_pipe.md
NETLIST_CONE_PIPE -- requirements
Module: netlist_cone_pipe

Interface
REQ-001 The block SHALL expose parameter W, default 4, meaning bit width of each lane operand.
REQ-002 The block SHALL expose parameter LANES, default 2, meaning number of independent bitwise lanes.
REQ-003 The block SHALL expose parameter CW, default 4, meaning width of the beat counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  upstream beat present.
REQ-007 in_ready  output  1  block accepts beat this cycle.
REQ-008 in_a, in_b, in_c  input  LANES*W each  operands; lane k occupies bits [k*W +: W].
REQ-009 in_mode  input  1  0 = pass (one result per beat), 1 = accumulate (one result per frame).
REQ-010 in_last  input  1  final beat of frame; ignored in pass mode.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_y  output  LANES*W  result, same lane packing as inputs.
REQ-014 out_cnt  output  CW  beats contributing to out_y.

Function
REQ-015 Per lane and bit, the cone SHALL compute f = MAJ(~(a&b), c, a^b), where MAJ is the 2-of-3 majority.
REQ-016 The datapath SHALL be a 2-stage pipeline: S1 registers f, mode, and last; S2 holds the output register.
REQ-017 A beat SHALL be accepted only on a cycle with in_valid && in_ready.
REQ-018 in_ready SHALL equal !S1_valid || S1 advancing this cycle; this gives full throughput with no bubble.
REQ-019 S1 SHALL advance into S2 when S2 is empty, or when S2 emits (out_valid && out_ready), or when S1 holds a non-emitting accumulate beat.
REQ-020 In pass mode, latency SHALL be 2 cycles from acceptance to out_valid; out_y = f and out_cnt = 1.
REQ-021 In accumulate mode, an LANES*W accumulator SHALL XOR in f for each beat leaving S1.
REQ-022 In accumulate mode, only the beat with last=1 SHALL load S2: out_y = acc ^ f and out_cnt = beats in frame including last.
REQ-023 After the last beat is loaded into S2, the accumulator SHALL clear to 0 and the counter to 0 in the same cycle.
REQ-024 The beat counter SHALL saturate at 2^CW-1; further beats still accumulate but do not increment the counter.
REQ-025 A mode change mid-frame SHALL cause the pass beat to emit normally and SHALL leave the accumulator and counter untouched; the frame resumes on the next accumulate beat.
REQ-026 While out_valid=1 and out_ready=0, out_y, out_cnt and out_valid SHALL hold stable, and S1 SHALL stall if it holds an emitting beat.
REQ-027 When S2 emits and S1 loads S2 in the same cycle, out_valid SHALL remain 1 with the new data, and no beat SHALL be lost or duplicated.
REQ-028 Lanes SHALL be fully independent; there SHALL be no inter-lane carry.

Reset
REQ-029 When rst_n=0 at a clock edge, the block SHALL set S1_valid=0, out_valid=0, out_y=0, out_cnt=0, accumulator=0 and counter=0.
REQ-030 During reset, in_ready SHALL be 0; in the first cycle after rst_n returns to 1, in_ready SHALL be 1.
REQ-031 Reset asserted mid-frame or with out_valid pending SHALL discard all in-flight data, with no output after release.

Verification
REQ-032 Pass, W=4, lane0 a=1100 b=1010 c=0110, out_ready=1 -> lane0 out_y=0110, out_cnt=1, out_valid 2 cycles after acceptance.
REQ-033 Accumulate frame: beat1 as REQ-032, beat2 a=1111 b=0000 c=0001 last=1 -> one output, lane0 out_y=1001, out_cnt=2, no output after beat1.
REQ-034 Backpressure: stream 4 pass beats with out_ready=0 for 5 cycles -> in_ready drops after 2 accepted, out_y stable; after release all 4 results emerge in order, none duplicated.
REQ-035 Saturation: CW=2, 6-beat accumulate frame -> out_cnt=3, out_y = XOR of all 6 f values.
REQ-036 Reset mid-frame: 2 accumulate beats, rst_n=0 one cycle, then a 1-beat frame with last=1 -> out_y = that beat's f only, out_cnt=1.
REQ-037 Full-throughput stream of 100 random pass beats, out_ready=1 -> 100 outputs, matching the reference model bit-exact, with in_ready constantly 1.
